// File: rtl/life_pkg.sv
// Shared types and rule masks for the row-sweep Life engine.
// Holds the FSM state enum and the B3/S23 and HighLife B36/S23 masks.
package life_pkg;

  typedef enum logic {
    IDLE,
    STEP
  } state_t;

  localparam logic [8:0] B3_MASK    = 9'b000001000;
  localparam logic [8:0] S23_MASK   = 9'b000001100;
  localparam logic [8:0] HL_BIRTH   = 9'b001001000;
  localparam logic [8:0] HL_SURVIVE = 9'b000001100;

endpackage

// File: rtl/life_row_calc.sv
// Combinational next-state for one board row from its above/cur/below rows.
// Ports: above/cur/below rows, wrap, birth/survive masks -> new_row, new_pop.
module life_row_calc
  import life_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  input  logic             wrap,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic [WIDTH-1:0] new_row,
  output logic [CW-1:0]    new_pop
);

  // Extended rows: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
  logic [WIDTH+1:0] ea;
  logic [WIDTH+1:0] ec;
  logic [WIDTH+1:0] eb;
  logic [3:0]       n;

  always_comb begin
    ea = {wrap & above[0], above, wrap & above[WIDTH-1]};
    ec = {wrap & cur[0], cur, wrap & cur[WIDTH-1]};
    eb = {wrap & below[0], below, wrap & below[WIDTH-1]};
  end

  always_comb begin
    n       = '0;
    new_row = '0;
    new_pop = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(ea[c]) + 4'(ea[c+1]) + 4'(ea[c+2])
        + 4'(ec[c]) + 4'(ec[c+2])
        + 4'(eb[c]) + 4'(eb[c+1]) + 4'(eb[c+2]);
      new_row[c] = cur[c] ? survive_mask[n]
                          : birth_mask[n];
      new_pop = new_pop + CW'(new_row[c]);
    end
  end

endmodule

// File: rtl/life_row_engine.sv
// Game-of-Life board updated one row per clock by an in-place sweep.
// Ports: clk, reset, seed/seed_ena chain, life_step, rd_row -> rd_data,
// torus_last, busy, done, generation, population.
module life_row_engine
  import life_pkg::*;
#(
  parameter int         WIDTH        = 32,
  parameter int         HEIGHT       = 32,
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK,
  parameter bit         WRAP         = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                seed,
  input  logic                                seed_ena,
  input  logic                                life_step,
  input  logic [$clog2(HEIGHT)-1:0]           rd_row,
  output logic [WIDTH-1:0]                    rd_data,
  output logic                                torus_last,
  output logic                                busy,
  output logic                                done,
  output logic [15:0]                         generation,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   population
);

  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH * HEIGHT + 1);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] board [HEIGHT];
  logic [WIDTH-1:0] save_row0;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] cur_row;
  logic [WIDTH-1:0] below_row;
  logic [WIDTH-1:0] new_row;
  logic [WIDTH-1:0] rd_mux;
  logic [CW-1:0]    new_pop;
  logic [RW-1:0]    row_q;
  logic [PW-1:0]    acc_q;
  logic             shift;
  logic             accept;
  logic             last_row;

  always_comb begin
    shift    = (state_q == IDLE) && seed_ena;
    accept   = (state_q == IDLE) && life_step
             && !seed_ena;
    last_row = (row_q == RW'(HEIGHT - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = STEP;
      STEP: if (last_row) state_d = IDLE;
    endcase
  end

  // Row below the last one comes from the copy of row 0
  // taken before the sweep overwrote it.
  always_comb begin
    cur_row   = '0;
    below_row = WRAP ? save_row0 : '0;
    for (int i = 0; i < HEIGHT; i++) begin
      if (row_q == RW'(i)) cur_row = board[i];
    end
    for (int i = 0; i < HEIGHT - 1; i++) begin
      if (row_q == RW'(i)) below_row = board[i+1];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      if (rd_row == RW'(i)) rd_mux = board[i];
    end
  end

  life_row_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .above        (prev_q),
    .cur          (cur_row),
    .below        (below_row),
    .wrap         (WRAP),
    .birth_mask   (BIRTH_MASK),
    .survive_mask (SURVIVE_MASK),
    .new_row      (new_row),
    .new_pop      (new_pop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HEIGHT; i++) begin
        board[i] <= '0;
      end
    end else if (shift) begin
      board[0] <= {board[0][WIDTH-2:0], seed};
      for (int i = 1; i < HEIGHT; i++) begin
        board[i] <= {board[i][WIDTH-2:0],
                     board[i-1][WIDTH-1]};
      end
    end else if (state_q == STEP) begin
      for (int i = 0; i < HEIGHT; i++) begin
        if (row_q == RW'(i)) board[i] <= new_row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      prev_q     <= '0;
      save_row0  <= '0;
      acc_q      <= '0;
      done       <= 1'b0;
      generation <= '0;
      population <= '0;
      rd_data    <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      rd_data <= rd_mux;
      if (accept) begin
        save_row0 <= board[0];
        prev_q    <= WRAP ? board[HEIGHT-1] : '0;
        row_q     <= '0;
        acc_q     <= '0;
      end
      if (state_q == STEP) begin
        prev_q <= cur_row;
        row_q  <= row_q + RW'(1);
        acc_q  <= acc_q + PW'(new_pop);
        if (last_row) begin
          done       <= 1'b1;
          generation <= generation + 16'd1;
          population <= acc_q + PW'(new_pop);
        end
      end
    end
  end

  always_comb begin
    busy       = (state_q == STEP);
    torus_last = board[HEIGHT-1][WIDTH-1];
  end

endmodule
